// File: rtl/cbus_mem_responder.sv
`default_nettype none
// ============================================================================
// cbus_mem_responder : cache-bus burst memory worker (FIXED/INCR/WRAP, strobed
//                      writes, programmable first-beat latency)
// Revision: 1.0
// ============================================================================
module cbus_mem_responder #(
  parameter int          MEM_WORDS = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [150:0] creq,
  output logic [65:0]  cresp
);

  localparam int        AW             = $clog2(MEM_WORDS);
  localparam logic [1:0] c_BURST_FIXED = 2'd0;
  localparam logic [1:0] c_BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic        w_valid;
  logic        w_is_write;
  logic [2:0]  w_size;
  logic [63:0] w_addr;
  logic [7:0]  w_strobe;
  logic [63:0] w_data;
  logic [7:0]  w_len;
  logic [1:0]  w_burst;

  assign w_valid    = creq[150];
  assign w_is_write = creq[149];
  assign w_size     = creq[148:146];
  assign w_addr     = creq[145:82];
  assign w_strobe   = creq[81:74];
  assign w_data     = creq[73:10];
  assign w_len      = creq[9:2];
  assign w_burst    = creq[1:0];

  state_t      r_state;
  logic        r_ready;
  logic        r_last;
  logic [63:0] r_data;
  logic [7:0]  r_beat;
  logic [3:0]  r_wait;
  logic        r_is_write;
  logic [2:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_cur;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;

  logic [63:0] r_mem [MEM_WORDS];

  logic [63:0] w_step;
  logic [63:0] w_bytes;
  logic [63:0] w_lower;
  logic [63:0] w_inc;
  logic [63:0] w_next;
  logic [63:0] w_rd_addr;
  logic [63:0] w_rd_off;
  logic [63:0] w_wr_off;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic        w_we;
  logic        w_unused;

  always_comb begin
    w_step  = 64'd1 << r_size;
    w_bytes = {55'd0, ({1'b0, r_len} + 9'd1)} << r_size;
    w_lower = r_addr & ~(w_bytes - 64'd1);
    w_inc   = r_cur + w_step;
    case (r_burst)
      c_BURST_FIXED: w_next = r_cur;
      c_BURST_WRAP:  w_next = (w_inc == w_lower + w_bytes) ? w_lower : w_inc;
      default:       w_next = w_inc;
    endcase
  end

  // The read port is addressed one cycle ahead of the beat it serves.
  always_comb begin
    case (r_state)
      S_IDLE:  w_rd_addr = w_addr;
      S_BURST: w_rd_addr = w_next;
      default: w_rd_addr = r_cur;
    endcase
  end

  assign w_rd_off = w_rd_addr - BASE_ADDR;
  assign w_wr_off = r_cur - BASE_ADDR;
  assign w_rd_idx = w_rd_off[AW+2:3];
  assign w_wr_idx = w_wr_off[AW+2:3];
  assign w_unused = ^{w_rd_off[63:AW+3], w_rd_off[2:0], w_wr_off[63:AW+3], w_wr_off[2:0]};

  assign w_we = (r_state == S_BURST) && w_valid && r_is_write;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strobe[b]) r_mem[w_wr_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= 64'd0;
      r_beat     <= 8'd0;
      r_wait     <= 4'd0;
      r_is_write <= 1'b0;
      r_size     <= 3'd0;
      r_addr     <= 64'd0;
      r_cur      <= 64'd0;
      r_len      <= 8'd0;
      r_burst    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_is_write <= w_is_write;
            r_size     <= w_size;
            r_addr     <= w_addr;
            r_cur      <= w_addr;
            r_len      <= w_len;
            r_burst    <= w_burst;
            r_beat     <= 8'd0;
            if (LATENCY == 0) begin
              r_state <= S_BURST;
              r_ready <= 1'b1;
              r_last  <= (w_len == 8'd0);
              if (!w_is_write) r_data <= r_mem[w_rd_idx];
            end else begin
              r_state <= S_WAIT;
              r_wait  <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (!w_valid) begin
            r_state <= S_IDLE;
          end else if (r_wait == 4'd0) begin
            r_state <= S_BURST;
            r_ready <= 1'b1;
            r_last  <= (r_len == 8'd0);
            if (!r_is_write) r_data <= r_mem[w_rd_idx];
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_BURST: begin
          if (!w_valid || (r_beat == r_len)) begin
            r_state <= w_valid ? S_DONE : S_IDLE;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
          end else begin
            r_beat <= r_beat + 8'd1;
            r_cur  <= w_next;
            r_last <= ((r_beat + 8'd1) == r_len);
            if (!r_is_write) r_data <= r_mem[w_rd_idx];
          end
        end
        S_DONE: begin
          // Hold off until valid drops so a lingering request is not re-served.
          if (!w_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cresp = {r_ready, r_last, r_data};

endmodule
`default_nettype wire

// File: tb/tb_cbus_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cbus_mem_responder : vector table + randomized bursts vs. a word-level model
// Revision: 1.0
// ============================================================================
module tb_cbus_mem_responder;

  localparam int          LAT = 2;
  localparam int          MW  = 65536;
  localparam logic [63:0] B   = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m_valid, m_wr;
  logic [2:0]  m_size;
  logic [63:0] m_addr, m_data;
  logic [7:0]  m_strb, m_len;
  logic [1:0]  m_burst;
  logic [150:0] creq;
  logic [65:0]  cresp;
  logic        s_ready, s_last;
  logic [63:0] s_data;

  assign creq    = {m_valid, m_wr, m_size, m_addr, m_strb, m_data, m_len, m_burst};
  assign s_ready = cresp[65];
  assign s_last  = cresp[64];
  assign s_data  = cresp[63:0];

  cbus_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(B), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  typedef logic [0:63][63:0] dvec_t;
  typedef logic [0:63][7:0]  svec_t;

  typedef struct {
    bit          wr;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          hold;
    int          abort_after;
    svec_t       st;
    dvec_t       wd;
    bit          use_exp;
    dvec_t       exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] mdl [int];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [2:0] size, input logic [63:0] addr,
                              input logic [7:0] len, input logic [1:0] burst, input int hold);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.len = len; v.burst = burst;
    v.hold = hold; v.abort_after = 0; v.use_exp = 1'b0;
    v.st = '1; v.wd = '0; v.exp = '0;
    return v;
  endfunction

  // Byte address of beat k, straight from the burst definitions.
  function automatic logic [63:0] beat_addr(input vec_t v, input int k);
    logic [63:0] step, bytes, lower;
    step = 64'd1 << v.size;
    case (v.burst)
      FIXED: return v.addr;
      WRAP: begin
        bytes = 64'(int'(v.len) + 1) * step;
        lower = v.addr - (v.addr % bytes);
        return lower + (((v.addr - lower) + 64'(k) * step) % bytes);
      end
      default: return v.addr + 64'(k) * step;
    endcase
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'(((a - B) >> 3) % 64'(MW));
  endfunction

  task automatic run(input vec_t v);
    int n, last_cyc, k, idx;
    logic [63:0] w;
    n        = int'(v.len) + 1;
    last_cyc = (v.abort_after > 0) ? LAT + v.abort_after : LAT + n;
    m_valid = 1'b1; m_wr = v.wr; m_size = v.size; m_addr = v.addr;
    m_len = v.len; m_burst = v.burst; m_data = v.wd[0]; m_strb = v.st[0];
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      k = cyc - (LAT + 1);
      @(negedge clk);
      chk("ready", {63'd0, s_ready}, {63'd0, (k >= 0 && k < n)});
      chk("last",  {63'd0, s_last},  {63'd0, (k >= 0 && k == int'(v.len))});
      if (k >= 0 && k < n) begin
        idx = widx(beat_addr(v, k));
        if (v.wr) begin
          w = mdl.exists(idx) ? mdl[idx] : 'x;
          for (int b = 0; b < 8; b++) if (v.st[k][b]) w[8*b +: 8] = v.wd[k][8*b +: 8];
          mdl[idx] = w;
        end else begin
          chk("rdata", s_data, v.use_exp ? v.exp[k] : mdl[idx]);
        end
      end
      @(posedge clk); #1;
      if (k + 1 >= 0 && k + 1 < n) begin
        m_data = v.wd[k+1];
        m_strb = v.st[k+1];
      end
    end
    if (v.abort_after > 0) begin
      m_valid = 1'b0;
      @(posedge clk); #1;
      repeat (2) begin
        @(negedge clk);
        chk("abort_ready", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1;
      end
    end else begin
      repeat (v.hold) begin
        @(negedge clk);
        chk("done_ready", {63'd0, s_ready}, 64'd0);
        chk("done_last",  {63'd0, s_last},  64'd0);
        @(posedge clk); #1;
      end
      m_valid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("idle_ready", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   pick;

    reset = 1'b1;
    m_valid = 1'b1; m_wr = 1'b1; m_size = 3'd3; m_addr = B + 64'h200;
    m_strb = 8'hFF; m_data = 64'hBAD0_BAD0_BAD0_BAD0; m_len = 8'd0; m_burst = INCR;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_last",  {63'd0, s_last},  64'd0);
      chk("rst_data",  s_data, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_ready", {63'd0, s_ready}, 64'd0);
      chk("post_rst_data",  s_data, 64'd0);
      @(posedge clk); #1;
    end

    v = mk(1, 3, B, 3, INCR, 0);
    v.wd[0] = 64'h1111_1111_1111_1111; v.wd[1] = 64'h2222_2222_2222_2222;
    v.wd[2] = 64'h3333_3333_3333_3333; v.wd[3] = 64'h4444_4444_4444_4444;
    tbl.push_back(v);
    v.wr = 0; v.use_exp = 1; v.exp = v.wd; tbl.push_back(v);
    v = mk(1, 3, B + 8, 0, INCR, 0); v.wd[0] = '1; tbl.push_back(v);
    v = mk(1, 3, B + 8, 0, INCR, 0); v.wd[0] = 64'h0000_00CD_0000_0000; v.st[0] = 8'h10;
    tbl.push_back(v);
    v = mk(0, 3, B + 8, 0, INCR, 0); v.use_exp = 1; v.exp[0] = 64'hFFFF_FFCD_FFFF_FFFF;
    tbl.push_back(v);
    v = mk(1, 3, B, 7, INCR, 0);
    for (int i = 0; i < 8; i++) v.wd[i] = 64'(i);
    tbl.push_back(v);
    v = mk(0, 3, B + 64'h28, 7, WRAP, 0); v.use_exp = 1;
    v.exp[0] = 5; v.exp[1] = 6; v.exp[2] = 7; v.exp[3] = 0;
    v.exp[4] = 1; v.exp[5] = 2; v.exp[6] = 3; v.exp[7] = 4;
    tbl.push_back(v);
    v = mk(0, 3, B + 64'h10, 3, FIXED, 3); v.use_exp = 1;
    for (int i = 0; i < 4; i++) v.exp[i] = 64'd2;
    tbl.push_back(v);
    v = mk(1, 3, B + 64'h100, 15, INCR, 0);
    for (int i = 0; i < 16; i++) v.wd[i] = 64'hA000 + 64'(i);
    tbl.push_back(v);
    v = mk(1, 3, B + 64'h100, 15, INCR, 0); v.abort_after = 2;
    for (int i = 0; i < 16; i++) v.wd[i] = 64'hB000 + 64'(i);
    tbl.push_back(v);
    v = mk(0, 3, B + 64'h100, 15, INCR, 0); v.use_exp = 1;
    for (int i = 0; i < 16; i++) v.exp[i] = (i < 2) ? 64'hB000 + 64'(i) : 64'hA000 + 64'(i);
    tbl.push_back(v);
    v = mk(1, 3, B + 64'(MW) * 8, 0, INCR, 0); v.wd[0] = 64'hDEAD; tbl.push_back(v);
    v = mk(0, 3, B, 0, INCR, 1); v.use_exp = 1; v.exp[0] = 64'hDEAD; tbl.push_back(v);
    v = mk(0, 2, B, 3, INCR, 0); v.use_exp = 1;
    v.exp[0] = 64'hDEAD; v.exp[1] = 64'hDEAD; v.exp[2] = 1; v.exp[3] = 1;
    tbl.push_back(v);
    v = mk(0, 2, B + 64'h0C, 3, WRAP, 0); v.use_exp = 1;
    v.exp[0] = 1; v.exp[1] = 64'hDEAD; v.exp[2] = 64'hDEAD; v.exp[3] = 1;
    tbl.push_back(v);
    v = mk(0, 3, B + 64'h10, 1, RSVD, 0); v.use_exp = 1; v.exp[0] = 2; v.exp[1] = 3;
    tbl.push_back(v);

    foreach (tbl[i]) run(tbl[i]);

    // Reset while waiting for the first beat: nothing may come out.
    v = mk(0, 3, B, 3, INCR, 0);
    m_valid = 1'b1; m_wr = 1'b0; m_size = 3'd3; m_addr = B; m_len = 8'd3; m_burst = INCR;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstwait_ready", {63'd0, s_ready}, 64'd0);
      chk("rstwait_last",  {63'd0, s_last},  64'd0);
      @(posedge clk); #1;
    end
    m_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    v = mk(1, 3, B, 63, INCR, 0);
    for (int i = 0; i < 64; i++) v.wd[i] = {$urandom, $urandom};
    run(v);

    for (int t = 0; t < 40; t++) begin
      v = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), B, 8'd0,
             2'($urandom_range(0, 3)), $urandom_range(0, 2));
      if (v.burst == WRAP) begin
        pick  = $urandom_range(0, 4);
        v.len = 8'((1 << pick) - 1);
        v.addr = B + (64'($urandom_range(0, 255)) & ~((64'd1 << v.size) - 64'd1));
      end else begin
        v.len  = 8'($urandom_range(0, 15));
        v.addr = B + 64'($urandom_range(0, 255));
      end
      if (v.len > 0 && $urandom_range(0, 7) == 0) v.abort_after = $urandom_range(1, int'(v.len));
      for (int i = 0; i <= int'(v.len); i++) begin
        v.wd[i] = {$urandom, $urandom};
        v.st[i] = 8'($urandom);
      end
      run(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
